// File: rtl/lane_serialize.sv
// ============================================================================
// Module   : lane_serialize
// Brief    : Splits each wide input word into LANES beats, lane 0 first, with
//            an end-of-transaction flag on the last beat. Optional macro
//            LANE_SERIALIZE_ACTIVE_EN adds a per-word active-lane count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lane_serialize #(
  parameter int DIN   = 8,
  parameter int LANES = 4,
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1,
`ifdef LANE_SERIALIZE_ACTIVE_EN
  localparam int ACTW = $clog2(LANES + 1),
  localparam int DW   = LANES * DIN + ACTW
`else
  localparam int DW   = LANES * DIN
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [DW-1:0]   din_data,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [DIN:0]    dout_data
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDXW-1:0]        r_idx;
  logic [IDXW-1:0]        w_idx_nxt;
  logic [LANES*DIN-1:0]   r_wreg;
  logic [IDXW-1:0]        w_lastidx;
  logic [DIN-1:0]         w_lane;
  logic                   w_is_last;
  logic                   w_load;
  logic                   w_word_live;

`ifdef LANE_SERIALIZE_ACTIVE_EN
  logic [IDXW-1:0]        r_lastidx;
  logic [ACTW-1:0]        w_act;
  logic [ACTW-1:0]        w_act_clamp;
  logic [IDXW-1:0]        w_new_last;

  assign w_act       = din_data[DW-1 -: ACTW];
  assign w_act_clamp = (w_act > ACTW'(LANES)) ? ACTW'(LANES) : w_act;
  // Zero-active words are consumed without producing any beat.
  assign w_word_live = (w_act != '0);
  assign w_new_last  = IDXW'(w_act_clamp - ACTW'(1));
  assign w_lastidx   = r_lastidx;
`else
  assign w_word_live = 1'b1;
  assign w_lastidx   = IDXW'(LANES - 1);
`endif

  always_comb begin
    w_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r_idx == IDXW'(k)) w_lane = r_wreg[k*DIN +: DIN];
    end
  end

  assign w_is_last  = (r_idx == w_lastidx);
  assign dout_valid = (r_state == S_BUSY);
  assign dout_data  = {w_is_last, w_lane};
  // Accepting on the eot beat lets back-to-back words stream without a bubble.
  assign din_ready  = (r_state == S_IDLE) || (dout_ready && w_is_last);
  assign w_load     = din_valid && din_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_idx_nxt   = '0;
          w_state_nxt = w_word_live ? S_BUSY : S_IDLE;
        end
      end
      S_BUSY: begin
        if (dout_ready) begin
          if (w_is_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = (w_load && w_word_live) ? S_BUSY : S_IDLE;
          end else begin
            w_idx_nxt = r_idx + IDXW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wreg  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) r_wreg <= din_data[LANES*DIN-1:0];
    end
  end

`ifdef LANE_SERIALIZE_ACTIVE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastidx <= IDXW'(LANES - 1);
    end else if (w_load) begin
      r_lastidx <= w_new_last;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lane_serialize.sv
// Directed bench for lane_serialize: a LANES=4 instance and a LANES=1 instance.
`default_nettype none

module tb_lane_serialize;

`ifdef LANE_SERIALIZE_ACTIVE_EN
  localparam int W4 = 35;
  localparam int W1 = 9;
`else
  localparam int W4 = 32;
  localparam int W1 = 8;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          din4_valid = 1'b0;
  logic          din4_ready;
  logic [W4-1:0] din4_data = '0;
  logic          dout4_valid;
  logic          dout4_ready = 1'b0;
  logic [8:0]    dout4_data;

  logic          din1_valid = 1'b0;
  logic          din1_ready;
  logic [W1-1:0] din1_data = '0;
  logic          dout1_valid;
  logic          dout1_ready = 1'b0;
  logic [8:0]    dout1_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lane_serialize #(.DIN(8), .LANES(4)) u4 (
    .clk(clk), .rst(rst),
    .din_valid(din4_valid), .din_ready(din4_ready), .din_data(din4_data),
    .dout_valid(dout4_valid), .dout_ready(dout4_ready), .dout_data(dout4_data)
  );

  lane_serialize #(.DIN(8), .LANES(1)) u1 (
    .clk(clk), .rst(rst),
    .din_valid(din1_valid), .din_ready(din1_ready), .din_data(din1_data),
    .dout_valid(dout1_valid), .dout_ready(dout1_ready), .dout_data(dout1_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data is only compared when a beat is expected to be valid.
  task automatic exp4(input string tag, input logic v, input logic [8:0] d, input logic r);
    #1;
    chk({tag, ".valid"}, 64'(dout4_valid), 64'(v));
    if (v) chk({tag, ".data"}, 64'(dout4_data), 64'(d));
    chk({tag, ".ready"}, 64'(din4_ready), 64'(r));
  endtask

  task automatic exp1(input string tag, input logic v, input logic [8:0] d, input logic r);
    #1;
    chk({tag, ".valid"}, 64'(dout1_valid), 64'(v));
    if (v) chk({tag, ".data"}, 64'(dout1_data), 64'(d));
    chk({tag, ".ready"}, 64'(din1_ready), 64'(r));
  endtask

  task automatic set4(input logic [2:0] act, input logic [31:0] w);
    din4_data = W4'({act, w});
  endtask

  initial begin
    logic [31:0] word;
    int k;
    int cyc;

    // Reset state
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst4.valid", 64'(dout4_valid), 64'd0);
    chk("rst4.ready", 64'(din4_ready), 64'd1);
    chk("rst4.data",  64'(dout4_data), 64'h000);
    chk("rst1.valid", 64'(dout1_valid), 64'd0);
    chk("rst1.data",  64'(dout1_data), 64'h100);

    // Single word, full-rate output
    dout4_ready = 1'b1;
    din4_valid  = 1'b1;
    set4(3'd4, 32'h44332211);
    exp4("single.idle", 1'b0, 9'h000, 1'b1);
    step();
    din4_valid = 1'b0;
    exp4("single.b0", 1'b1, 9'h011, 1'b0); step();
    exp4("single.b1", 1'b1, 9'h022, 1'b0); step();
    exp4("single.b2", 1'b1, 9'h033, 1'b0); step();
    exp4("single.b3", 1'b1, 9'h144, 1'b1); step();
    exp4("single.done", 1'b0, 9'h000, 1'b1);

    // Back-to-back words with no bubble
    din4_valid = 1'b1;
    set4(3'd4, 32'h44332211);
    step();
    set4(3'd4, 32'h88776655);
    exp4("b2b.b0", 1'b1, 9'h011, 1'b0); step();
    exp4("b2b.b1", 1'b1, 9'h022, 1'b0); step();
    exp4("b2b.b2", 1'b1, 9'h033, 1'b0); step();
    exp4("b2b.b3", 1'b1, 9'h144, 1'b1); step();
    din4_valid = 1'b0;
    exp4("b2b.b4", 1'b1, 9'h055, 1'b0); step();
    exp4("b2b.b5", 1'b1, 9'h066, 1'b0); step();
    exp4("b2b.b6", 1'b1, 9'h077, 1'b0); step();
    exp4("b2b.b7", 1'b1, 9'h188, 1'b1); step();
    exp4("b2b.done", 1'b0, 9'h000, 1'b1);

    // Backpressure: ready pattern 1,0,0 repeating
    word = 32'h0D0C0B0A;
    din4_valid = 1'b1;
    set4(3'd4, word);
    step();
    din4_valid = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 20) begin
      dout4_ready = (cyc % 3 == 0);
      exp4($sformatf("bp.c%0d", cyc), 1'b1,
           {(k == 3), word[8*k +: 8]}, dout4_ready && (k == 3));
      step();
      if (dout4_ready) k++;
      cyc++;
    end
    chk("bp.all_lanes", 64'(k), 64'd4);
    dout4_ready = 1'b1;
    exp4("bp.done", 1'b0, 9'h000, 1'b1);

    // Reset in the middle of a word
    din4_valid = 1'b1;
    set4(3'd4, 32'hDDCCBBAA);
    step();
    din4_valid = 1'b0;
    exp4("rmw.b0", 1'b1, 9'h0AA, 1'b0); step();
    exp4("rmw.b1", 1'b1, 9'h0BB, 1'b0); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp4("rmw.after_rst", 1'b0, 9'h000, 1'b1);
    din4_valid = 1'b1;
    set4(3'd4, 32'h04030201);
    step();
    din4_valid = 1'b0;
    exp4("rmw.n0", 1'b1, 9'h001, 1'b0); step();
    exp4("rmw.n1", 1'b1, 9'h002, 1'b0); step();
    exp4("rmw.n2", 1'b1, 9'h003, 1'b0); step();
    exp4("rmw.n3", 1'b1, 9'h104, 1'b1); step();
    exp4("rmw.done", 1'b0, 9'h000, 1'b1);

    // LANES=1 instance at full rate
    dout1_ready = 1'b1;
    din1_valid  = 1'b1;
    din1_data   = W1'({1'b1, 8'hA5});
    exp1("l1.idle", 1'b0, 9'h000, 1'b1);
    step();
    din1_data = W1'({1'b1, 8'h5A});
    exp1("l1.b0", 1'b1, 9'h1A5, 1'b1);
    step();
    din1_valid = 1'b0;
    exp1("l1.b1", 1'b1, 9'h15A, 1'b1);
    step();
    exp1("l1.done", 1'b0, 9'h000, 1'b1);

`ifdef LANE_SERIALIZE_ACTIVE_EN
    // act=2: two beats, eot on lane 1
    din4_valid = 1'b1;
    set4(3'd2, 32'h44332211);
    step();
    din4_valid = 1'b0;
    exp4("act2.b0", 1'b1, 9'h011, 1'b0); step();
    exp4("act2.b1", 1'b1, 9'h122, 1'b1); step();
    exp4("act2.done", 1'b0, 9'h000, 1'b1);

    // act=0: accepted, no beat
    din4_valid = 1'b1;
    set4(3'd0, 32'h44332211);
    exp4("act0.accept", 1'b0, 9'h000, 1'b1);
    step();
    din4_valid = 1'b0;
    exp4("act0.nobeat", 1'b0, 9'h000, 1'b1);
    step();
    exp4("act0.still_idle", 1'b0, 9'h000, 1'b1);

    // act=7 clamps to all four lanes
    din4_valid = 1'b1;
    set4(3'd7, 32'h44332211);
    step();
    din4_valid = 1'b0;
    exp4("act7.b0", 1'b1, 9'h011, 1'b0); step();
    exp4("act7.b1", 1'b1, 9'h022, 1'b0); step();
    exp4("act7.b2", 1'b1, 9'h033, 1'b0); step();
    exp4("act7.b3", 1'b1, 9'h144, 1'b1); step();
    exp4("act7.done", 1'b0, 9'h000, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
